// File: rtl/vga_sync_gen.sv
// 640x480@60 sync/colour stage: decodes pixel counts into per-axis timing states and
// drives hsync/vsync/blank-gated RGB through a 2-stage pipeline aligned to the framebuffer read.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [15:0] H_Count_Value,
  input  logic [15:0] V_Count_Value,
  input  logic [11:0] pixel_rgb,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [1:0]  h_state,
  output logic [1:0]  v_state,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } axis_state_t;

  localparam logic [15:0] H_FP_START   = 16'(H_ACTIVE);
  localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_BP_START   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_TOTAL      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_FP_START   = 16'(V_ACTIVE);
  localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_BP_START   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_TOTAL      = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);

  // Counts past the total park the axis in BP, which also keeps it blanked and sync-inactive.
  function automatic axis_state_t decode(input logic [15:0] c, input logic [15:0] fp_start,
                                         input logic [15:0] sync_start,
                                         input logic [15:0] bp_start,
                                         input logic [15:0] total);
    if (c >= total)           return ST_BP;
    else if (c < fp_start)    return ST_ACTIVE;
    else if (c < sync_start)  return ST_FP;
    else if (c < bp_start)    return ST_SYNC;
    else                      return ST_BP;
  endfunction

  axis_state_t h_nx, v_nx, h_st, v_st;
  logic        s1_on, s1_hs, s1_vs;

  always_comb begin
    h_nx = decode(H_Count_Value, H_FP_START, H_SYNC_START, H_BP_START, H_TOTAL);
    v_nx = decode(V_Count_Value, V_FP_START, V_SYNC_START, V_BP_START, V_TOTAL);
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      h_st        <= ST_ACTIVE;
      v_st        <= ST_ACTIVE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      s1_on       <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
    end else begin
      h_st        <= h_nx;
      v_st        <= v_nx;
      pixel_x     <= (h_nx == ST_ACTIVE) ? H_Count_Value[9:0] : 10'd0;
      pixel_y     <= (v_nx == ST_ACTIVE) ? V_Count_Value[9:0] : 10'd0;
      frame_start <= (H_Count_Value == 16'd0) && (V_Count_Value == 16'd0);
      s1_on       <= (h_nx == ST_ACTIVE) && (v_nx == ST_ACTIVE);
      s1_hs       <= (h_nx == ST_SYNC);
      s1_vs       <= (v_nx == ST_SYNC);
    end
  end

  // Stage 2 samples pixel_rgb, which the framebuffer returns for the stage-1 coordinates.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
    end else begin
      video_on <= s1_on;
      hsync    <= s1_hs ? SYNC_POL : ~SYNC_POL;
      vsync    <= s1_vs ? SYNC_POL : ~SYNC_POL;
      {vga_r, vga_g, vga_b} <= s1_on ? pixel_rgb : 12'h000;
    end
  end

  assign h_state = h_st;
  assign v_state = v_st;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default active-low instance plus an active-high
// SYNC_POL=1 instance sharing the same count stimulus.
module tb_vga_sync_gen;

  logic        clk_25MHz = 1'b0;
  logic        rst;
  logic [15:0] H_Count_Value, V_Count_Value;
  logic [11:0] pixel_rgb, rgb_const;
  logic        fb_mode;

  logic [9:0]  pixel_x, pixel_y, p_pixel_x, p_pixel_y;
  logic        frame_start, hsync, vsync, video_on;
  logic        p_frame_start, p_hsync, p_vsync, p_video_on;
  logic [1:0]  h_state, v_state, p_h_state, p_v_state;
  logic [3:0]  vga_r, vga_g, vga_b, p_vga_r, p_vga_g, p_vga_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  // Framebuffer model: data for the stage-1 coordinates is presented during the following cycle.
  always_comb pixel_rgb = fb_mode ? {pixel_x[3:0], pixel_y[3:0], 4'h5} : rgb_const;

  vga_sync_gen dut (
    .clk_25MHz(clk_25MHz), .rst(rst), .H_Count_Value(H_Count_Value), .V_Count_Value(V_Count_Value),
    .pixel_rgb(pixel_rgb), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .h_state(h_state), .v_state(v_state), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_sync_gen #(.SYNC_POL(1'b1)) dut_pos (
    .clk_25MHz(clk_25MHz), .rst(rst), .H_Count_Value(H_Count_Value), .V_Count_Value(V_Count_Value),
    .pixel_rgb(pixel_rgb), .pixel_x(p_pixel_x), .pixel_y(p_pixel_y), .frame_start(p_frame_start),
    .h_state(p_h_state), .v_state(p_v_state), .hsync(p_hsync), .vsync(p_vsync),
    .video_on(p_video_on), .vga_r(p_vga_r), .vga_g(p_vga_g), .vga_b(p_vga_b)
  );

  task automatic drive(input int h, input int v);
    H_Count_Value = 16'(h);
    V_Count_Value = 16'(v);
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fb_mode = 1'b0; rgb_const = 12'hFFF;
    H_Count_Value = '0; V_Count_Value = '0;
    #1;
    n_assert++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL reset_sync: hs=%b vs=%b want 1/1", hsync, vsync); end
    n_assert++; if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin n_fail++; $display("FAIL reset_sync_pos: hs=%b vs=%b want 0/0", p_hsync, p_vsync); end
    n_assert++; if (video_on !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'h000) begin n_fail++; $display("FAIL reset_video: on=%b rgb=%h want 0/000", video_on, {vga_r, vga_g, vga_b}); end
    n_assert++; if (h_state !== 2'd0 || v_state !== 2'd0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_state: h=%0d v=%0d fs=%b want 0/0/0", h_state, v_state, frame_start); end
    @(negedge clk_25MHz); rst = 1'b0;
    drive(100, 5); drive(101, 5);
    n_assert++; if (video_on !== 1'b1 || pixel_x !== 10'd101) begin n_fail++; $display("FAIL pre_reset_active: on=%b x=%0d want 1/101", video_on, pixel_x); end
    #5 rst = 1'b1; #1;
    n_assert++; if (video_on !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'h000 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
      n_fail++; $display("FAIL midline_reset_video: on=%b rgb=%h x=%0d y=%0d want 0/000/0/0", video_on, {vga_r, vga_g, vga_b}, pixel_x, pixel_y); end
    @(negedge clk_25MHz); rst = 1'b0;
    drive(700, 490); drive(701, 490);
    n_assert++; if (hsync !== 1'b0 || vsync !== 1'b0 || p_hsync !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sync: hs=%b vs=%b phs=%b want 0/0/1", hsync, vsync, p_hsync); end
    #5 rst = 1'b1; #1;
    n_assert++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL midline_reset_sync: hs=%b vs=%b want 1/1", hsync, vsync); end
    n_assert++; if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin n_fail++; $display("FAIL midline_reset_sync_pos: hs=%b vs=%b want 0/0", p_hsync, p_vsync); end
    @(negedge clk_25MHz); rst = 1'b0;
    drive(10, 3);
    n_assert++; if (pixel_x !== 10'd10 || pixel_y !== 10'd3 || video_on !== 1'b0) begin n_fail++; $display("FAIL release_stage1: x=%0d y=%0d on=%b want 10/3/0", pixel_x, pixel_y, video_on); end
    drive(11, 3);
    n_assert++; if (video_on !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'hFFF) begin n_fail++; $display("FAIL release_stage2: on=%b rgb=%h want 1/fff", video_on, {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_line_sweep;
    int hs_low = 0, on_cnt = 0, h, p;
    logic [1:0] exp_st;
    logic exp_on, exp_hs;
    fb_mode = 1'b0; rgb_const = 12'hFFF;
    for (int i = 0; i <= 800; i++) begin
      h = i % 800;
      drive(h, 0);
      exp_st = (h < 640) ? 2'd0 : (h < 656) ? 2'd1 : (h < 752) ? 2'd2 : 2'd3;
      n_assert++; if (h_state !== exp_st) begin n_fail++; $display("FAIL line_hstate h=%0d: got %0d want %0d", h, h_state, exp_st); end
      n_assert++; if (pixel_x !== ((h < 640) ? 10'(h) : 10'd0)) begin n_fail++; $display("FAIL line_pixel_x h=%0d: got %0d", h, pixel_x); end
      if (i > 0) begin
        p = i - 1;
        exp_on = (p < 640);
        exp_hs = !(p >= 656 && p < 752);
        n_assert++; if (video_on !== exp_on) begin n_fail++; $display("FAIL line_video_on h=%0d: got %b want %b", p, video_on, exp_on); end
        n_assert++; if (hsync !== exp_hs || p_hsync !== !exp_hs) begin n_fail++; $display("FAIL line_hsync h=%0d: got %b/%b want %b/%b", p, hsync, p_hsync, exp_hs, !exp_hs); end
        n_assert++; if ({vga_r, vga_g, vga_b} !== (exp_on ? 12'hFFF : 12'h000)) begin n_fail++; $display("FAIL line_rgb h=%0d: got %h", p, {vga_r, vga_g, vga_b}); end
        if (hsync === 1'b0) hs_low++;
        if (video_on === 1'b1) on_cnt++;
      end
    end
    n_assert++; if (hs_low != 96) begin n_fail++; $display("FAIL line_hsync_width: got %0d want 96", hs_low); end
    n_assert++; if (on_cnt != 640) begin n_fail++; $display("FAIL line_active_width: got %0d want 640", on_cnt); end
  endtask

  task automatic test_frame_sweep;
    int hv[3] = '{0, 1, 700};
    int vs_low = 0, fs_cnt = 0, ph = 0, pv = 0;
    bit have_prev = 1'b0;
    logic [1:0] exp_st;
    logic exp_vs, exp_on;
    fb_mode = 1'b0; rgb_const = 12'hA5C;
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < 525; v++)
        for (int k = 0; k < 3; k++) begin
          drive(hv[k], v);
          exp_st = (v < 480) ? 2'd0 : (v < 490) ? 2'd1 : (v < 492) ? 2'd2 : 2'd3;
          n_assert++; if (v_state !== exp_st) begin n_fail++; $display("FAIL frame_vstate v=%0d: got %0d want %0d", v, v_state, exp_st); end
          n_assert++; if (frame_start !== (hv[k] == 0 && v == 0)) begin n_fail++; $display("FAIL frame_start h=%0d v=%0d: got %b", hv[k], v, frame_start); end
          if (frame_start === 1'b1) fs_cnt++;
          if (have_prev) begin
            exp_vs = !(pv >= 490 && pv < 492);
            exp_on = (ph < 640) && (pv < 480);
            n_assert++; if (vsync !== exp_vs || p_vsync !== !exp_vs) begin n_fail++; $display("FAIL frame_vsync v=%0d: got %b/%b want %b", pv, vsync, p_vsync, exp_vs); end
            n_assert++; if ({vga_r, vga_g, vga_b} !== (exp_on ? 12'hA5C : 12'h000)) begin n_fail++; $display("FAIL frame_rgb h=%0d v=%0d: got %h", ph, pv, {vga_r, vga_g, vga_b}); end
            if (vsync === 1'b0) vs_low++;
          end
          ph = hv[k]; pv = v; have_prev = 1'b1;
        end
    n_assert++; if (vs_low != 12) begin n_fail++; $display("FAIL frame_vsync_lines: got %0d want 12", vs_low); end
    n_assert++; if (fs_cnt != 2) begin n_fail++; $display("FAIL frame_start_count: got %0d want 2", fs_cnt); end
  endtask

  task automatic test_alignment;
    fb_mode = 1'b1;
    for (int h = 0; h <= 6; h++) drive(h, 7);
    n_assert++; if ({vga_r, vga_g, vga_b} !== 12'h575) begin n_fail++; $display("FAIL align_rgb: got %h want 575", {vga_r, vga_g, vga_b}); end
    n_assert++; if (pixel_x !== 10'd6 || pixel_y !== 10'd7) begin n_fail++; $display("FAIL align_xy: got %0d,%0d want 6,7", pixel_x, pixel_y); end
    fb_mode = 1'b0;
  endtask

  task automatic test_out_of_range;
    rgb_const = 12'hFFF;
    drive(900, 600); drive(900, 600);
    n_assert++; if (h_state !== 2'd3 || v_state !== 2'd3) begin n_fail++; $display("FAIL oor_state: got %0d/%0d want 3/3", h_state, v_state); end
    n_assert++; if (video_on !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h000) begin
      n_fail++; $display("FAIL oor_outputs: on=%b hs=%b vs=%b rgb=%h want 0/1/1/000", video_on, hsync, vsync, {vga_r, vga_g, vga_b}); end
    n_assert++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin n_fail++; $display("FAIL oor_xy: got %0d,%0d want 0,0", pixel_x, pixel_y); end
    drive(700, 5);
    n_assert++; if (h_state !== 2'd2 || v_state !== 2'd0) begin n_fail++; $display("FAIL backward_state: got %0d/%0d want 2/0", h_state, v_state); end
    drive(100, 5);
    n_assert++; if (h_state !== 2'd0 || hsync !== 1'b0 || pixel_x !== 10'd100) begin n_fail++; $display("FAIL backward_follow: h=%0d hs=%b x=%0d want 0/0/100", h_state, hsync, pixel_x); end
    drive(10, 480);
    n_assert++; if (v_state !== 2'd1 || pixel_y !== 10'd0) begin n_fail++; $display("FAIL v_fp_edge: v=%0d y=%0d want 1/0", v_state, pixel_y); end
    drive(10, 479);
    n_assert++; if (v_state !== 2'd0 || pixel_y !== 10'd479 || video_on !== 1'b0) begin n_fail++; $display("FAIL v_active_edge: v=%0d y=%0d on=%b want 0/479/0", v_state, pixel_y, video_on); end
    drive(10, 479);
    n_assert++; if (video_on !== 1'b1 || p_video_on !== 1'b1) begin n_fail++; $display("FAIL v_active_on: got %b/%b want 1/1", video_on, p_video_on); end
  endtask

  initial begin
    test_reset();
    test_line_sweep();
    test_frame_sweep();
    test_alignment();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
